// File: rtl/led_blink_driver_pkg.sv
// Shared definitions for the LED blink driver: FSM state encoding and
// default timing constants shared with the button debouncer.
package led_blink_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Default timings (clk cycles) shared with debounce_button.
  localparam int DEBOUNCE_CYCLES = 1_000_000;
  localparam int BLINK_CYCLES    = 5_000_000;

  localparam int DEF_CNT_W  = 32;
  localparam int DEF_PEND_W = 4;

  // Largest value representable in an unsigned counter of width w.
  function automatic int sat_max(input int w);
    return (32'sd1 <<< w) - 32'sd1;
  endfunction

endpackage

// File: rtl/led_blink_driver_sat_counter.sv
// Saturating up/down counter. Simultaneous inc and dec cancel out; an inc
// that would pass the maximum is refused and flagged on sat_drop.
module sat_up_down_counter
  import led_blink_driver_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q,
  output logic         sat_drop
);

  localparam logic [W-1:0] Q_MAX  = W'(sat_max(W));
  localparam logic [W-1:0] Q_ZERO = {W{1'b0}};
  localparam logic [W-1:0] Q_ONE  = W'(1);

  logic [W-1:0] q_next;

  // Next count and saturation drop decode.
  always_comb begin
    q_next   = q;
    sat_drop = 1'b0;
    if (inc && !dec) begin
      if (q == Q_MAX) begin
        sat_drop = 1'b1;
      end else begin
        q_next = q + Q_ONE;
      end
    end else if (dec && !inc) begin
      if (q != Q_ZERO) begin
        q_next = q - Q_ONE;
      end else begin
        q_next = q;
      end
    end else begin
      q_next = q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= Q_ZERO;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/led_blink_driver.sv
// LED blink driver: turns each single-cycle event pulse into one visible blink
// (ON_CYCLES high, then OFF_CYCLES forced low). Events arriving mid-blink are
// queued in a saturating pending counter and replayed back to back.
module led_blink_driver
  import led_blink_driver_pkg::*;
#(
  parameter int ON_CYCLES  = BLINK_CYCLES,
  parameter int OFF_CYCLES = BLINK_CYCLES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int PEND_W     = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              clr_ovf,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(ON_CYCLES);
  localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(OFF_CYCLES);
  localparam logic [CNT_W-1:0] T_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] T_ZERO  = {CNT_W{1'b0}};
  localparam logic [PEND_W-1:0] P_ZERO = {PEND_W{1'b0}};

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  timer;
  logic [CNT_W-1:0]  timer_next;
  logic              led_next;
  logic              pend_inc;
  logic              pend_dec;
  logic              sat_drop;

  // Pending queue: grows on pulses during a blink, shrinks when a queued blink starts.
  sat_up_down_counter #(
    .W(PEND_W)
  ) u_pending (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (pend_inc),
    .dec      (pend_dec),
    .q        (pending),
    .sat_drop (sat_drop)
  );

  // Next-state, phase timer and queue control. A pulse on the last GAP cycle
  // is counted and immediately consumed, so the FSM chains straight into ON.
  always_comb begin
    state_next = state;
    timer_next = timer;
    pend_inc   = 1'b0;
    pend_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pulse_in) begin
          state_next = ST_ON;
          timer_next = T_ONE;
        end else begin
          state_next = ST_IDLE;
          timer_next = T_ZERO;
        end
      end
      ST_ON: begin
        pend_inc = pulse_in;
        if (timer == ON_LIM) begin
          state_next = ST_GAP;
          timer_next = T_ONE;
        end else begin
          state_next = ST_ON;
          timer_next = timer + T_ONE;
        end
      end
      ST_GAP: begin
        pend_inc = pulse_in;
        if (timer == OFF_LIM) begin
          if ((pending != P_ZERO) || pulse_in) begin
            state_next = ST_ON;
            timer_next = T_ONE;
            pend_dec   = 1'b1;
          end else begin
            state_next = ST_IDLE;
            timer_next = T_ZERO;
          end
        end else begin
          state_next = ST_GAP;
          timer_next = timer + T_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        timer_next = T_ZERO;
      end
    endcase
    led_next = (state_next == ST_ON);
  end

  // State, timer and LED registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      timer <= T_ZERO;
      led   <= 1'b0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      led   <= led_next;
    end
  end

  // Sticky overflow flag; a new drop takes priority over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (sat_drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end else begin
      overflow <= overflow;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_led_blink_driver.sv
// Bench for led_blink_driver. A schedule of blink start cycles is derived
// from the event rules (each accepted event starts one period after the
// previous blink, or one cycle after the event if idle). Expected rises go
// into a queue that a separate monitor pops on every observed LED rise.
module tb_led_blink_driver;

  localparam int ON       = 4;
  localparam int OFF      = 3;
  localparam int PW       = 2;
  localparam int PERIOD   = ON + OFF;
  localparam int PEND_MAX = (1 << PW) - 1;

  logic          clk;
  logic          rst_n;
  logic          pulse_in;
  logic          clr_ovf;
  logic          led;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int cyc;
  int chk_cnt;
  int pass_cnt;

  int starts[$];
  int exp_rise[$];
  int last_start;
  bit have_last;
  bit m_ovf;

  led_blink_driver #(
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF),
    .CNT_W      (8),
    .PEND_W     (PW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .clr_ovf  (clr_ovf),
    .led      (led),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Blinks scheduled to start strictly after cycle c.
  function automatic int cnt_after(input int c);
    int n = 0;
    foreach (starts[i]) if (starts[i] > c) n++;
    return n;
  endfunction

  // True if some blink covers cycle c within len cycles of its start.
  function automatic bit in_window(input int c, input int len);
    foreach (starts[i]) if (starts[i] <= c && c < starts[i] + len) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    starts.delete();
    exp_rise.delete();
    have_last = 1'b0;
    last_start = 0;
    m_ovf = 1'b0;
  endtask

  // Drive one cycle of stimulus and update the reference schedule.
  task automatic drive(input bit p, input bit c);
    int t;
    int s;
    bit drop;
    @(negedge clk);
    pulse_in = p;
    clr_ovf  = c;
    t = cyc;
    drop = 1'b0;
    if (p) begin
      if (cnt_after(t + 1) >= PEND_MAX) begin
        drop = 1'b1;
      end else begin
        s = t + 1;
        if (have_last && last_start + PERIOD > s) s = last_start + PERIOD;
        starts.push_back(s);
        exp_rise.push_back(s);
        last_start = s;
        have_last = 1'b1;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  // Monitor: per-cycle output comparison plus rise scoreboard.
  initial begin
    bit prev_led;
    int hi_len;
    int c;
    int s;
    prev_led = 1'b0;
    hi_len = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_led = 1'b0;
        hi_len = 0;
      end else begin
        c = cyc;
        check("led", int'(led), int'(in_window(c, ON)));
        check("busy", int'(busy), int'(in_window(c, PERIOD)));
        check("pending", int'(pending), cnt_after(c));
        check("overflow", int'(overflow), int'(m_ovf));
        if (led && !prev_led) begin
          if (exp_rise.size() == 0) begin
            chk_cnt++;
            $display("FAIL rise_unexpected at cycle %0d: got a rise, expected none", c);
          end else begin
            s = exp_rise.pop_front();
            check("rise_time", c, s);
          end
        end
        if (!led && prev_led) check("on_len", hi_len, ON);
        hi_len = led ? hi_len + 1 : 0;
        prev_led = led;
      end
    end
  end

  // Stimulus.
  initial begin
    cyc = 0;
    chk_cnt = 0;
    pass_cnt = 0;
    model_clear();
    rst_n = 1'b0;
    pulse_in = 1'b0;
    clr_ovf = 1'b0;
    #1;
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_overflow", int'(overflow), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single blink.
    drive(1'b1, 1'b0); idle(10);
    // Two pulses two cycles apart.
    drive(1'b1, 1'b0); idle(1); drive(1'b1, 1'b0); idle(16);
    // Five pulses in one blink: saturation and overflow, then clear.
    repeat (5) drive(1'b1, 1'b0);
    idle(30); drive(1'b0, 1'b1); idle(3);
    // Pulse exactly on the final GAP cycle of a lone blink.
    drive(1'b1, 1'b0); idle(6); drive(1'b1, 1'b0); idle(16);
    // Held high for three cycles.
    repeat (3) drive(1'b1, 1'b0);
    idle(25);
    // Saturate, then a drop coincident with clr_ovf.
    repeat (4) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    idle(3); drive(1'b0, 1'b1); idle(30);

    // Asynchronous reset in the middle of an ON phase.
    drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("pre_reset_led", int'(led), 1);
    rst_n = 1'b0;
    pulse_in = 1'b0;
    clr_ovf = 1'b0;
    #1;
    check("async_rst_led", int'(led), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_pending", int'(pending), 0);
    check("async_rst_overflow", int'(overflow), 0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bit p;
      bit c;
      p = ($urandom_range(0, 9) < 3);
      c = ($urandom_range(0, 19) == 0);
      drive(p, c);
    end

    // Drain, bounded.
    for (int i = 0; i < 400 && (!have_last || cyc <= last_start + PERIOD + 2); i++) begin
      drive(1'b0, 1'b0);
    end
    idle(2);
    check("drain_rises_left", exp_rise.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
